// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: a WIDTH-bit operand pair is processed DIGIT bits per clock,
// least-significant digit first, through one DIGIT-bit adder with a registered carry.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, sub_q, sub_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT:0]   dig_sum;
  logic [WIDTH-1:0] res_next;
  logic             ovf_calc;

  always_comb begin
    dig_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    // New digit enters from the MSB side; after NDIG shifts it sits in its final position.
    res_next = (res_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Overflow is judged on the original operand signs, not on the inverted B.
    if (sub_q) begin
      ovf_calc = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
    end else begin
      ovf_calc = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sub_d   = sub_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          res_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          sub_d   = sub;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_sum[DIGIT];
        res_d   = res_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NDIG - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          sum_d   = res_next;
          cout_d  = dig_sum[DIGIT];
          ovf_d   = ovf_calc;
          zero_d  = (res_next == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sub_q   <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sub_q   <= sub_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five instances (DIGIT = 1,2,4,8,16) share one stimulus stream.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst, start, sub_i, cin_i;
  logic [15:0] a_i, b_i;
  logic [4:0]  busy_w, done_w, cout_w, ovf_w, zero_w;
  logic [15:0] sum_w [5];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    serial_addsub #(
      .WIDTH(16),
      .DIGIT(1 << g)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .sub  (sub_i),
      .a    (a_i),
      .b    (b_i),
      .cin  (cin_i),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .sum  (sum_w[g]),
      .cout (cout_w[g]),
      .ovf  (ovf_w[g]),
      .zero (zero_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] r;
    logic        v;
    r = {1'b0, x} + {1'b0, (s ? ~y : y)} + 17'(s ? 1'b1 : c);
    v = s ? ((x[15] != y[15]) && (r[15] != x[15])) : ((x[15] == y[15]) && (r[15] != x[15]));
    return {r[16], v, (r[15:0] == 16'h0), r[15:0]};
  endfunction

  function automatic logic [18:0] res_of(input int i);
    return {cout_w[i], ovf_w[i], zero_w[i], sum_w[i]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge; inputs are scrambled afterwards.
  task automatic start_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
    @(negedge clk);
    start = 1'b1;
    sub_i = s;
    a_i   = x;
    b_i   = y;
    cin_i = c;
    @(negedge clk);
    start = 1'b0;
    a_i   = 16'($urandom);
    b_i   = 16'($urandom);
    sub_i = ~s;
    cin_i = ~c;
  endtask

  // Follows all instances through one operation: busy/done per cycle, then the result.
  task automatic track(input string name, input logic [18:0] exp);
    logic [18:0] got [5];
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int k = 0; k <= 17; k++) begin
      for (int i = 0; i < 5; i++) begin
        int   ndig;
        logic [1:0] bd;
        ndig = 16 >> i;
        bd   = (k < ndig) ? 2'b10 : ((k == ndig) ? 2'b01 : 2'b00);
        check_eq($sformatf("%s busy/done d%0d k%0d", name, 1 << i, k),
                 32'({busy_w[i], done_w[i]}), 32'(bd));
        if (k == ndig) got[i] = res_of(i);
      end
      if (k < 17) @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("%s result d%0d", name, 1 << i), 32'(got[i]), 32'(exp));
    end
  endtask

  task automatic run_all(input string name, input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic c, input logic [18:0] exp);
    start_op(s, x, y, c);
    track(name, exp);
  endtask

  initial begin
    logic any_done;
    rst   = 1'b1;
    start = 1'b0;
    sub_i = 1'b0;
    cin_i = 1'b0;
    a_i   = 16'h0;
    b_i   = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("reset d%0d", 1 << i),
               32'({busy_w[i], done_w[i], res_of(i)}), 32'(0));
    end
    rst = 1'b0;

    // {cout, ovf, zero, sum}
    run_all("add 1234+4321",   1'b0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555});
    run_all("add ffff+0001",   1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    run_all("add 7fff+0+cin",  1'b0, 16'h7FFF, 16'h0000, 1'b1, {1'b0, 1'b1, 1'b0, 16'h8000});
    run_all("sub 0005-0007",   1'b1, 16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    run_all("sub 8000-0001",   1'b1, 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});

    // Start during busy is ignored; start held in the done cycle is accepted (DIGIT=4 lane).
    do_reset();
    start_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    start = 1'b1;
    sub_i = 1'b0;
    a_i   = 16'hFFFF;
    b_i   = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("busy-start done", 32'({busy_w[2], done_w[2]}), 32'(2'b01));
    check_eq("busy-start result", 32'(res_of(2)), 32'({1'b0, 1'b0, 1'b0, 16'h5555}));
    start = 1'b1;
    sub_i = 1'b1;
    a_i   = 16'h0005;
    b_i   = 16'h0007;
    cin_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = 16'h0BAD;
    for (int k = 5; k <= 8; k++) begin
      check_eq($sformatf("b2b busy k%0d", k), 32'({busy_w[2], done_w[2]}), 32'(2'b10));
      @(negedge clk);
    end
    check_eq("b2b done", 32'({busy_w[2], done_w[2]}), 32'(2'b01));
    check_eq("b2b result", 32'(res_of(2)), 32'({1'b0, 1'b0, 1'b0, 16'hFFFE}));
    @(negedge clk);
    check_eq("b2b done width", 32'(done_w[2]), 32'(0));

    // Reset two cycles into an operation, with start high at the same edge.
    do_reset();
    start_op(1'b0, 16'h1234, 16'h4321, 1'b0);
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("mid-op reset d%0d", 1 << i),
               32'({busy_w[i], done_w[i], res_of(i)}), 32'(0));
    end
    any_done = 1'b0;
    for (int k = 0; k < 18; k++) begin
      any_done = any_done | (|done_w) | (|busy_w);
      @(negedge clk);
    end
    check_eq("no activity after reset", 32'(any_done), 32'(0));
    run_all("after reset", 1'b0, 16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555});

    for (int n = 0; n < 1000; n++) begin
      logic        s, c;
      logic [15:0] x, y;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = 16'($urandom);
      run_all($sformatf("rand%0d %s %h %h c%0d", n, s ? "sub" : "add", x, y, c),
              s, x, y, c, model(s, x, y, c));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, through a DIGIT-bit full-adder chain with a registered inter-digit carry. A start/done handshake lets it share one small adder datapath across wide operands. It is the sequential, configurable successor to the fixed 4-bit ripple-carry adder, and it adds subtraction and status flags.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle.
- sub  input  1  0 = add, 1 = subtract; latched on accepted start.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in for add; ignored for subtract. Latched on accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result outputs valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE: a start that is high at an edge is accepted. At that edge the block:
  - latches A;
  - latches B' = sub ? ~b : b;
  - sets the carry register to sub ? 1 : cin;
  - clears the digit counter;
  - goes to RUN.
- RUN: each edge adds digit k of A and B' plus the carry register. The DIGIT-bit sum is shifted into an internal result register from the MSB side. The carry register updates and k increments.
- After the edge that processes digit NDIG−1, the block:
  - loads sum, cout, ovf and zero from the final values;
  - pulses done;
  - returns to IDLE.
- ovf rule: add sets ovf when a[MSB]==b[MSB] and sum[MSB]!=a[MSB]. Subtract sets ovf when a[MSB]!=b[MSB] and sum[MSB]!=a[MSB]. Original, uninverted operands are used.
- Result arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH−1.
- sum, cout, ovf and zero hold their last completed values until the next completion. They never show partial results.
- start while busy: ignored. No queuing, no effect on the operation in flight.
- Input changes after acceptance have no effect.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0. The carry register, digit counter and internal registers are also cleared.
- start accepted at edge E0. busy=1 from after E0. Digits are processed at edges E1..E_NDIG.
- After E_NDIG: done=1 for exactly one cycle, busy=0, result outputs updated.
- Latency: done is observed NDIG cycles after the cycle in which start was high.
- Throughput: one operation per NDIG cycles. busy is low during the done cycle, so a start held high in the done cycle is accepted at the following edge.
- DIGIT == WIDTH: NDIG=1. done follows the accepted start by one cycle and busy pulses high for one cycle.
- rst high at any edge, including mid-RUN: the operation aborts, no done is produced, and all outputs return to reset values. A start that is high at the same edge as rst is ignored.

## Test plan
- WIDTH=16, DIGIT=4, add 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, zero=0. done arrives exactly 4 cycles after start and is high for 1 cycle. busy is high for the 4 cycles before it.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Then add 0x7FFF + 0x0000, cin=1 -> sum=0x8000, ovf=1, cout=0.
- Subtract 0x0005 − 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000 − 0x0001 -> sum=0x7FFF, cout=1, ovf=1. Both run with cin=1 to confirm cin is ignored.
- Pulse start with new operands during busy -> it is ignored and the first result is unchanged. Hold start high with new operands during the done cycle -> the second operation is accepted and its done arrives 4 cycles after that start.
- Assert rst 2 cycles into an operation -> no done, all outputs 0, block idle. A subsequent start completes normally with correct values.
- Repeat the first and third scenarios with DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency). Run 1000 random operand/sub/cin sets against a reference model for DIGIT ∈ {1,2,4,8,16}.
